// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the CDC sequence checker.
package cdc_pkg;

    localparam logic ST_SEED  = 1'b0;
    localparam logic ST_TRACK = 1'b1;

    localparam int DEF_N  = 8;
    localparam int DEF_CW = 16;

    // True when more than one bit of v is set.
    function automatic logic multi_bit(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
module sat_counter
    import cdc_pkg::*;
#(
    parameter int W = DEF_CW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ena) begin
            if (clr) begin
                q <= '0;
            end else if (inc && (q != '1)) begin
                q <= q + W'(1);
            end
        end
    end

endmodule

// File: rtl/cdc_seq_checker.sv
// Sequence checker for words crossing a CDC synchronizer.
// Optional coherence counter enabled by CDC_SEQ_CHK_COHERENCE_EN.
module cdc_seq_checker
    import cdc_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CW       = DEF_CW,
    parameter int LOSS_THR = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          clr,
    input  logic          vld,
    input  logic [N-1:0]  data,
`ifdef CDC_SEQ_CHK_COHERENCE_EN
    output logic [CW-1:0] incoh_cnt,
`endif
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] xfer_cnt
);

    typedef enum logic {
        SEED  = ST_SEED,
        TRACK = ST_TRACK
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_nxt;
    logic [3:0]   miss_run;
    logic [3:0]   miss_nxt;
    logic [3:0]   miss_inc;
    logic         err_nxt;
    logic         xfer_inc;

    assign miss_inc = miss_run + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            exp_q     <= '0;
            miss_run  <= '0;
            err_pulse <= 1'b0;
        end else if (ena) begin
            state     <= state_nxt;
            exp_q     <= exp_nxt;
            miss_run  <= miss_nxt;
            err_pulse <= err_nxt;
        end else begin
            err_pulse <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        miss_nxt  = miss_run;
        err_nxt   = 1'b0;
        xfer_inc  = 1'b0;
        if (clr) begin
            state_nxt = SEED;
            exp_nxt   = '0;
            miss_nxt  = '0;
        end else if (vld) begin
            xfer_inc = 1'b1;
            unique case (state)
                SEED: begin
                    exp_nxt   = data + N'(1);
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (data == exp_q) begin
                        exp_nxt  = data + N'(1);
                        miss_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                        exp_nxt = exp_q + N'(1);
                        // Too many misses in a row: give up and re-seed.
                        if (miss_inc == 4'(LOSS_THR)) begin
                            state_nxt = SEED;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_inc;
                        end
                    end
                end
                default: state_nxt = SEED;
            endcase
        end
    end

    assign locked = (state == TRACK);

    sat_counter #(.W(CW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (err_nxt),
        .q     (err_cnt)
    );

    sat_counter #(.W(CW)) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (xfer_inc),
        .q     (xfer_cnt)
    );

`ifdef CDC_SEQ_CHK_COHERENCE_EN
    logic [N-1:0] prev;
    logic         incoh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else if (ena) begin
            prev <= data;
        end
    end

    // Gray-coded source: more than one changed bit means torn capture.
    assign incoh = multi_bit(64'(data ^ prev));

    sat_counter #(.W(CW)) u_incoh_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (incoh),
        .q     (incoh_cnt)
    );
`endif

endmodule

// File: doc/cdc_seq_checker.md
Name: cdc_seq_checker

Overview:
- Downstream consumer of the synchronizer outputs. Runs in the destination clock domain.
- Accepts words delivered by a synchronizer path, each qualified by a single-cycle valid. The source increments its data by 1 (mod 2^N) on every transfer.
- Checks each received word against the expected sequence and counts transfers and mismatches. Tracks lock to the sequence so the board can show sync versus no-sync failure rates.

Parameters:
- N, 8, data width of the checked word.
- CW, 16, width of the transfer and error counters.
- LOSS_THR, 4, number of consecutive mismatches that drops lock (legal range 1..15).

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  reset: asynchronous, active-low. Clock is clk.
- ena  input  1  global enable. When low, all state is frozen and vld is ignored.
- clr  input  1  synchronous clear of counters and FSM.
- vld  input  1  single-cycle strobe: data is valid this cycle.
- data  input  N  word from the synchronizer path.
- locked  output  1  high while the FSM is in TRACK.
- err_pulse  output  1  one-cycle pulse on each mismatch.
- err_cnt  output  CW  saturating mismatch count.
- xfer_cnt  output  CW  saturating count of accepted vld strobes.

Behaviour:
- Reset values: locked=0, err_pulse=0, err_cnt=0, xfer_cnt=0. Internally exp=0, miss_run=0, state=SEED.
- All outputs are registered. Every update is visible on the clk edge after the edge that samples vld=1 (1-cycle latency).
- FSM has two states, SEED and TRACK.
  - SEED: on vld, load exp<=data+1 (mod 2^N), xfer_cnt++, go to TRACK. No error is possible in SEED.
  - TRACK, vld with data==exp: exp<=data+1, miss_run<=0, xfer_cnt++.
  - TRACK, vld with data!=exp: err_cnt++ (saturating), err_pulse=1 for one cycle, xfer_cnt++, exp<=exp+1 (source assumed to keep advancing), miss_run++.
  - If the mismatch makes miss_run reach LOSS_THR: go to SEED, miss_run<=0, locked falls on the same edge.
- Wrap-around: exp wraps at 2^N-1 to 0. Data 8'hFF followed by 8'h00 is a match.
- Saturation: err_cnt and xfer_cnt stop at all-ones and never wrap.
- clr=1: go to SEED, zero both counters, exp and miss_run, and drop locked. clr has priority over a simultaneous vld; that vld is discarded.
- ena=0: hold every register including err_pulse=0. A vld seen while ena=0 is lost. clr is also ignored while ena=0.
- rst_n asserted mid-operation: all registers go to reset values immediately. The first vld after release re-seeds.
- Back-to-back vld on consecutive cycles is legal and each is checked independently.

Optional Feature:
- Macro: CDC_SEQ_CHK_COHERENCE_EN.
- Defined: adds one extra output port, incoh_cnt [CW-1:0], saturating.
  - A register samples data every enabled cycle, regardless of vld.
  - incoh_cnt increments when data differs from the previous cycle's sample in more than one bit position. This detects incoherent multi-bit capture when the source sends Gray-coded data.
  - It is cleared by rst_n and clr.
- Not defined: the port and its logic are absent; everything else is identical.

Decomposition:
- Shared package cdc_pkg:
  - state encoding constants ST_SEED=1'b0, ST_TRACK=1'b1.
  - default width constants (N, CW).
  - a popcount>1 function used by the coherence check.
- One natural sub-module: sat_counter (width parameter, inc, clr, ena, q). It is instantiated for err_cnt, xfer_cnt and, optionally, incoh_cnt.

Test Plan (N=8, CW=16, LOSS_THR=4):
- Seed and track: vld with data 8'h10,8'h11,8'h12 -> locked=1 from the first vld+1 cycle, xfer_cnt=3, err_cnt=0, err_pulse never high.
- Wrap: seed 8'hFE, then 8'hFF, then 8'h00 -> err_cnt=0, xfer_cnt=3.
- Single glitch: seed 8'h20, then 8'h21, 8'h5A, 8'h23 -> err_cnt=1, err_pulse high exactly one cycle after the 8'h5A vld, locked stays 1.
- Loss of lock: seed 8'h00, then four vld of 8'hAA -> err_cnt=4, locked=0 after the fourth; the next vld of 8'h40 re-seeds and 8'h41 matches.
- clr with simultaneous vld: clr=1 and vld=1 in the same cycle -> counters=0, locked=0, that vld not counted.
- ena/reset: ena=0 with three vld -> no change. rst_n pulsed low while locked -> all outputs 0 asynchronously.
